// File: rtl/jk_excite_drv.sv
// JK excitation driver: turns a target word into one cycle of J/K codes for a bank of JK flip-flops.
// Optional macro JK_TOGGLE_EXCITE_EN drives changing bits with the toggle code 11 instead of set/reset.
module jk_excite_drv #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tgt_valid,
  input  logic [WIDTH-1:0]   tgt,
  output logic               tgt_ready,
  output logic [2*WIDTH-1:0] jk,
  output logic [WIDTH-1:0]   q_model,
  output logic               done,
  output logic [7:0]         chg_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             armed;
  logic             same_done;
  logic [WIDTH-1:0] tgt_lat;
  logic             xfer;
  logic             tgt_differs;

  assign xfer        = tgt_valid && tgt_ready;
  assign tgt_differs = (tgt != q_model);

  function automatic logic [7:0] popcnt(input logic [WIDTH-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && tgt_differs) state_nxt = DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // jk is decoded from the latched target and the old q_model, so it is only live in DRIVE
  always_comb begin
    tgt_ready = armed && (state == IDLE);
    done      = (state == SETTLE) || same_done;
    jk        = '0;
    if (state == DRIVE) begin
      for (int i = 0; i < WIDTH; i++) begin
`ifdef JK_TOGGLE_EXCITE_EN
        jk[2*i +: 2] = {q_model[i] ^ tgt_lat[i], q_model[i] ^ tgt_lat[i]};
`else
        jk[2*i +: 2] = {~q_model[i] & tgt_lat[i], q_model[i] & ~tgt_lat[i]};
`endif
      end
    end
  end

  // armed holds tgt_ready low until the first edge after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      same_done <= 1'b0;
      tgt_lat   <= '0;
      q_model   <= '0;
      chg_cnt   <= '0;
    end else begin
      armed     <= 1'b1;
      same_done <= xfer && !tgt_differs;
      if (xfer && tgt_differs) begin
        tgt_lat <= tgt;
      end
      if (state == DRIVE) begin
        q_model <= tgt_lat;
        chg_cnt <= chg_cnt + popcnt(tgt_lat ^ q_model);
      end
    end
  end

endmodule
